execute_multicycle: RTL and testbench

EXECUTE_MULTICYCLE -- requirements
Module: execute_multicycle

---
 rtl/execute_pkg.sv | 27 ++
 rtl/vector_lane_alu.sv | 39 +++
 rtl/execute_multicycle.sv | 163 ++++++++++++++++
 tb/tb_execute_multicycle.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/execute_pkg.sv
// Shared opcode and FSM state types plus default widths for the multicycle execute stage.
package execute_pkg;

   localparam int OPCODE_W          = 3;
   localparam int DEF_SCALAR_W      = 48;
   localparam int DEF_VECTOR_W      = 8;
   localparam int DEF_VECTOR_SIZE   = 6;
   localparam int DEF_LANES_PER_CYC = 2;

   typedef enum logic [OPCODE_W-1:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_SHL  = 3'b101,
      OP_SHR  = 3'b110,
      OP_PASS = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

endpackage

// File: rtl/vector_lane_alu.sv
// Single-lane combinational ALU with optional unsigned saturation for ADD/SUB.
module vector_lane_alu
   import execute_pkg::*;
#(
   parameter int WIDTH = DEF_VECTOR_W
) (
   input  alu_op_e          op,
   input  logic             saturate,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result
);

   localparam logic [WIDTH-1:0] WIDTH_L = WIDTH'(WIDTH);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] shamt;

   always_comb begin
      // NOTE: every output gets a default before the case so no latch is inferred.
      sum    = {1'b0, a} + {1'b0, b};
      diff   = {1'b0, a} - {1'b0, b};
      shamt  = b % WIDTH_L;
      result = '0;
      unique case (op)
         OP_ADD:  result = (saturate && sum[WIDTH])  ? '1 : sum[WIDTH-1:0];
         OP_SUB:  result = (saturate && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SHL:  result = a << shamt;
         OP_SHR:  result = a >> shamt;
         OP_PASS: result = b;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/execute_multicycle.sv
// Execute stage: scalar ops finish in one cycle, vector ops run LANES_PER_CYCLE lanes per beat.
module execute_multicycle
   import execute_pkg::*;
#(
   parameter int SCALAR_DATA_WIDTH = DEF_SCALAR_W,
   parameter int VECTOR_DATA_WIDTH = DEF_VECTOR_W,
   parameter int VECTOR_SIZE       = DEF_VECTOR_SIZE,
   parameter int LANES_PER_CYCLE   = DEF_LANES_PER_CYC
) (
   input  logic                                           clk,
   input  logic                                           rst_n,
   input  logic                                           inValid,
   output logic                                           inReady,
   input  logic [SCALAR_DATA_WIDTH-1:0]                   scalarData1,
   input  logic [SCALAR_DATA_WIDTH-1:0]                   scalarData2,
   input  logic [SCALAR_DATA_WIDTH-1:0]                   scalarInmediate,
   input  logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]  vectorOperand1,
   input  logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]  vectorOperand2,
   input  logic [OPCODE_W-1:0]                            aluControl,
   input  logic                                           useInmediate,
   input  logic                                           isScalarInstruction,
   input  logic                                           writeScalar,
   input  logic                                           saturate,
   output logic                                           outValid,
   input  logic                                           outReady,
   output logic [SCALAR_DATA_WIDTH-1:0]                   out,
   output logic [SCALAR_DATA_WIDTH-1:0]                   dataToWrite,
   output logic                                           N,
   output logic                                           Z,
   output logic                                           V,
   output logic                                           C
);

   localparam int NUM_BEATS = VECTOR_SIZE / LANES_PER_CYCLE;
   localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam int LANE_W    = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
   localparam int MSB       = SCALAR_DATA_WIDTH - 1;
   localparam logic [BEAT_W-1:0]            LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
   localparam logic [SCALAR_DATA_WIDTH-1:0] SW_L      = SCALAR_DATA_WIDTH'(SCALAR_DATA_WIDTH);

   typedef logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0] vec_t;

   state_e            state;
   logic [BEAT_W-1:0] beat;
   vec_t              op1_q, op2_q, res_q;
   alu_op_e           op_q;
   logic              sat_q;
   logic              accept;

   assign inReady = (state == IDLE) || (state == DONE && outReady);
   assign accept  = inValid && inReady;
   assign out     = res_q;

   // Scalar result and flags are formed from the live operands and latched on accept.
   logic [SCALAR_DATA_WIDTH-1:0] s_b, s_shamt, s_res;
   logic [SCALAR_DATA_WIDTH:0]   s_sum, s_diff;
   logic                         s_c, s_v;

   always_comb begin
      s_b     = useInmediate ? scalarInmediate : scalarData2;
      s_sum   = {1'b0, scalarData1} + {1'b0, s_b};
      s_diff  = {1'b0, scalarData1} - {1'b0, s_b};
      s_shamt = s_b % SW_L;
      s_res   = '0;
      s_c     = 1'b0;
      s_v     = 1'b0;
      unique case (alu_op_e'(aluControl))
         OP_ADD: begin
            s_res = s_sum[MSB:0];
            s_c   = s_sum[SCALAR_DATA_WIDTH];
            s_v   = (scalarData1[MSB] == s_b[MSB]) && (s_res[MSB] != scalarData1[MSB]);
         end
         OP_SUB: begin
            s_res = s_diff[MSB:0];
            s_c   = ~s_diff[SCALAR_DATA_WIDTH];
            s_v   = (scalarData1[MSB] != s_b[MSB]) && (s_res[MSB] != scalarData1[MSB]);
         end
         OP_AND:  s_res = scalarData1 & s_b;
         OP_OR:   s_res = scalarData1 | s_b;
         OP_XOR:  s_res = scalarData1 ^ s_b;
         OP_SHL:  s_res = scalarData1 << s_shamt;
         OP_SHR:  s_res = scalarData1 >> s_shamt;
         OP_PASS: s_res = s_b;
         default: s_res = '0;
      endcase
   end

   logic [LANE_W-1:0]            base_lane;
   logic [VECTOR_DATA_WIDTH-1:0] lane_res [LANES_PER_CYCLE];

   assign base_lane = LANE_W'(beat * LANES_PER_CYCLE);

   for (genvar i = 0; i < LANES_PER_CYCLE; i++) begin : g_lane
      vector_lane_alu #(.WIDTH(VECTOR_DATA_WIDTH)) u_alu (
         .op       (op_q),
         .saturate (sat_q),
         .a        (op1_q[base_lane + LANE_W'(i)]),
         .b        (op2_q[base_lane + LANE_W'(i)]),
         .result   (lane_res[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         beat        <= '0;
         outValid    <= 1'b0;
         res_q       <= '0;
         dataToWrite <= '0;
         N           <= 1'b0;
         Z           <= 1'b0;
         V           <= 1'b0;
         C           <= 1'b0;
         op1_q       <= '0;
         op2_q       <= '0;
         op_q        <= OP_ADD;
         sat_q       <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
         unique case (state)
            IDLE, DONE: begin
               if (accept) begin
                  op1_q       <= vectorOperand1;
                  op2_q       <= vectorOperand2;
                  op_q        <= alu_op_e'(aluControl);
                  sat_q       <= saturate;
                  dataToWrite <= writeScalar ? scalarData2 : vectorOperand2;
                  beat        <= '0;
                  if (isScalarInstruction) begin
                     state    <= DONE;
                     outValid <= 1'b1;
                     res_q    <= s_res;
                     N        <= s_res[MSB];
                     Z        <= (s_res == '0);
                     V        <= s_v;
                     C        <= s_c;
                  end else begin
                     state    <= BUSY;
                     outValid <= 1'b0;
                  end
               end else if (state == DONE && outReady) begin
                  state    <= IDLE;
                  outValid <= 1'b0;
               end
            end
            BUSY: begin
               for (int i = 0; i < LANES_PER_CYCLE; i++) begin
                  res_q[base_lane + LANE_W'(i)] <= lane_res[i];
               end
               if (beat == LAST_BEAT) begin
                  state    <= DONE;
                  outValid <= 1'b1;
                  beat     <= '0;
               end else begin
                  beat <= beat + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_execute_multicycle.sv
// Directed self-checking bench for execute_multicycle at default parameters.
module tb_execute_multicycle;

   logic            clk;
   logic            rst_n;
   logic            inValid, inReady;
   logic [47:0]     scalarData1, scalarData2, scalarInmediate;
   logic [5:0][7:0] vectorOperand1, vectorOperand2;
   logic [2:0]      aluControl;
   logic            useInmediate, isScalarInstruction, writeScalar, saturate;
   logic            outValid, outReady;
   logic [47:0]     out, dataToWrite;
   logic            N, Z, V, C;

   int n_cmp = 0;
   int n_mis = 0;

   execute_multicycle dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .inValid             (inValid),
      .inReady             (inReady),
      .scalarData1         (scalarData1),
      .scalarData2         (scalarData2),
      .scalarInmediate     (scalarInmediate),
      .vectorOperand1      (vectorOperand1),
      .vectorOperand2      (vectorOperand2),
      .aluControl          (aluControl),
      .useInmediate        (useInmediate),
      .isScalarInstruction (isScalarInstruction),
      .writeScalar         (writeScalar),
      .saturate            (saturate),
      .outValid            (outValid),
      .outReady            (outReady),
      .out                 (out),
      .dataToWrite         (dataToWrite),
      .N                   (N),
      .Z                   (Z),
      .V                   (V),
      .C                   (C)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one vector op and checks outValid rises exactly four cycles after accept.
   task automatic run_vector(input string tag, input logic [2:0] op,
                             input logic [47:0] a, input logic [47:0] b, input logic sat);
      vectorOperand1      = a;
      vectorOperand2      = b;
      aluControl          = op;
      saturate            = sat;
      isScalarInstruction = 1'b0;
      writeScalar         = 1'b0;
      inValid             = 1'b1;
      step();
      inValid        = 1'b0;
      vectorOperand1 = '1;
      vectorOperand2 = '0;
      aluControl     = 3'b111;
      saturate       = ~sat;
      check({tag, "_lat1"}, 48'(outValid), 48'd0);
      step();
      check({tag, "_lat2"}, 48'(outValid), 48'd0);
      step();
      check({tag, "_lat3"}, 48'(outValid), 48'd0);
      step();
      check({tag, "_lat4"}, 48'(outValid), 48'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      inValid = 1'b0; outReady = 1'b0;
      scalarData1 = '0; scalarData2 = '0; scalarInmediate = '0;
      vectorOperand1 = '0; vectorOperand2 = '0;
      aluControl = '0; useInmediate = 1'b0; isScalarInstruction = 1'b0;
      writeScalar = 1'b0; saturate = 1'b0;

      #2;
      check("rst_outValid", 48'(outValid), 48'd0);
      check("rst_out", out, 48'd0);
      check("rst_dtw", dataToWrite, 48'd0);
      check("rst_flags", 48'({N, Z, V, C}), 48'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      step();
      check("inReady_after_rst", 48'(inReady), 48'd1);

      // Scalar ADD overflow into the sign bit
      scalarData1 = 48'h7FFF_FFFF_FFFF; scalarData2 = 48'h1; aluControl = 3'b000;
      isScalarInstruction = 1'b1; writeScalar = 1'b1; outReady = 1'b1; inValid = 1'b1;
      step();
      inValid = 1'b0; scalarData1 = '0; scalarData2 = 48'hDEAD;
      check("add_outValid", 48'(outValid), 48'd1);
      check("add_out", out, 48'h8000_0000_0000);
      check("add_nzvc", 48'({N, Z, V, C}), 48'b1010);
      check("add_dtw", dataToWrite, 48'h1);
      step();
      check("add_release", 48'(outValid), 48'd0);

      // Scalar SUB using the immediate as B
      scalarData1 = 48'd5; scalarData2 = 48'h123; scalarInmediate = 48'd5;
      useInmediate = 1'b1; aluControl = 3'b001; inValid = 1'b1;
      step();
      inValid = 1'b0; useInmediate = 1'b0;
      check("sub_out", out, 48'd0);
      check("sub_nzvc", 48'({N, Z, V, C}), 48'b0101);
      step();

      // Vector ADD without and with saturation; flags keep the SUB values
      run_vector("vadd", 3'b000, 48'hF0F0_F0F0_F0F0, 48'h2020_2020_2020, 1'b0);
      check("vadd_out", out, 48'h1010_1010_1010);
      check("vadd_nzvc", 48'({N, Z, V, C}), 48'b0101);
      check("vadd_dtw", dataToWrite, 48'h2020_2020_2020);
      step();
      check("vadd_release", 48'(outValid), 48'd0);

      outReady = 1'b0;
      run_vector("vsat", 3'b000, 48'hF0F0_F0F0_F0F0, 48'h2020_2020_2020, 1'b1);
      check("vsat_out", out, 48'hFFFF_FFFF_FFFF);
      check("vsat_nzvc", 48'({N, Z, V, C}), 48'b0101);

      // Next scalar OR is presented while the result is held
      scalarData1 = 48'hF0; scalarData2 = 48'h0F; aluControl = 3'b011;
      isScalarInstruction = 1'b1; writeScalar = 1'b0;
      vectorOperand2 = 48'h0605_0403_0201; inValid = 1'b1;
      #1;
      check("hold_inReady0", 48'(inReady), 48'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         check("hold_outValid", 48'(outValid), 48'd1);
         check("hold_out", out, 48'hFFFF_FFFF_FFFF);
         check("hold_inReady", 48'(inReady), 48'd0);
      end
      outReady = 1'b1;
      #1;
      check("b2b_inReady", 48'(inReady), 48'd1);
      step();
      inValid = 1'b0;
      check("b2b_outValid", 48'(outValid), 48'd1);
      check("or_out", out, 48'hFF);
      check("or_nzvc", 48'({N, Z, V, C}), 48'b0000);
      check("or_dtw", dataToWrite, 48'h0605_0403_0201);
      step();
      check("or_release", 48'(outValid), 48'd0);

      // Saturating vector SUB clamps underflowing lanes to zero
      run_vector("vsub", 3'b001, 48'h3010_3010_3010, 48'h2020_2020_2020, 1'b1);
      check("vsub_out", out, 48'h1000_1000_1000);
      step();

      // Vector shift amount wraps modulo the lane width; saturate is ignored
      run_vector("vshl", 3'b101, 48'h0101_0101_0101, 48'h0909_0909_0909, 1'b1);
      check("vshl_out", out, 48'h0202_0202_0202);
      step();

      // Reset during BUSY beat 1 discards the operation
      vectorOperand1 = 48'h1111_1111_1111; vectorOperand2 = 48'h2222_2222_2222;
      aluControl = 3'b100; isScalarInstruction = 1'b0; inValid = 1'b1;
      step();
      inValid = 1'b0;
      step();
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_outValid", 48'(outValid), 48'd0);
      check("mid_rst_out", out, 48'd0);
      check("mid_rst_dtw", dataToWrite, 48'd0);
      #2 rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check("post_rst_quiet", 48'(outValid), 48'd0);
      end

      // Scalar SHL with amount 49 wraps to 1
      scalarData1 = 48'd1; scalarData2 = 48'd49; aluControl = 3'b101;
      isScalarInstruction = 1'b1; inValid = 1'b1;
      step();
      inValid = 1'b0;
      check("shl_outValid", 48'(outValid), 48'd1);
      check("shl_out", out, 48'd2);
      check("shl_nzvc", 48'({N, Z, V, C}), 48'b0000);
      step();

      // Scalar SHR logical and PASS B via immediate
      scalarData1 = 48'h8000_0000_0000; scalarData2 = 48'd47; aluControl = 3'b110; inValid = 1'b1;
      step();
      inValid = 1'b0;
      check("shr_out", out, 48'd1);
      step();
      scalarInmediate = 48'hABC; useInmediate = 1'b1; aluControl = 3'b111; inValid = 1'b1;
      step();
      inValid = 1'b0;
      check("pass_out", out, 48'hABC);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
